// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Define MC_ADDI_EN to add the addi path (IMM_EXEC/IMM_WB); otherwise opcode 001000 is illegal.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ior_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_source,
   output logic [2:0]       alu_op,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             instr_done,
   output logic             illegal_op,
   output logic             mem_timeout,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_IMM_EXEC = 4'd11,
      S_IMM_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t             state_q, state_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               wait_s;
   logic               timeout_s;
   state_t             end_next_s;

   assign wait_s     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
   // Ready in the limit cycle wins over the abort.
   assign timeout_s  = wait_s && !mem_ready && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
   assign end_next_s = run ? S_FETCH : S_IDLE;
   assign state      = state_q;

   // Next-state and memory-wait counter logic
   always_comb begin
      state_d = state_q;
      if (wait_s && !mem_ready && !timeout_s) begin
         tmo_d = tmo_q + TMO_W'(1);
      end else begin
         tmo_d = '0;
      end
      case (state_q)
         S_IDLE:     state_d = run ? S_FETCH : S_IDLE;
         S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC_R;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
               OP_ADDI:      state_d = S_IMM_EXEC;
`endif
               default:      state_d = end_next_s;
            endcase
         end
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (timeout_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM_RD;
            end
         end
         S_MEM_WB:   state_d = end_next_s;
         S_MEM_WR: begin
            if (mem_ready) begin
               state_d = end_next_s;
            end else if (timeout_s) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_MEM_WR;
            end
         end
         S_EXEC_R:   state_d = S_ALU_WB;
         S_ALU_WB:   state_d = end_next_s;
         S_BRANCH:   state_d = end_next_s;
         S_JUMP:     state_d = end_next_s;
`ifdef MC_ADDI_EN
         S_IMM_EXEC: state_d = S_IMM_WB;
         S_IMM_WB:   state_d = end_next_s;
`endif
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode from the registered state, with the few Mealy terms
   always_comb begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ior_d         = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 3'b000;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      mem_timeout   = timeout_s;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: illegal_op = 1'b0;
`ifdef MC_ADDI_EN
               OP_ADDI: illegal_op = 1'b0;
`endif
               default: begin
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            ior_d    = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WR: begin
            mem_write  = 1'b1;
            ior_d      = 1'b1;
            instr_done = mem_ready;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
         end
         S_ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            instr_done = 1'b1;
         end
`ifdef MC_ADDI_EN
         S_IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_IMM_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
         end
`endif
         default: mem_timeout = timeout_s;
      endcase
   end

   // State and timeout counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: instruction-level model builds a per-cycle expectation queue.
// Honours MC_ADDI_EN in the same way as the design.
module tb_multicycle_control;

   localparam int TMO = 16;

   logic        clk, rst_n, run, mem_ready;
   logic [5:0]  opcode;
   logic        mem_read, mem_write, ior_d, ir_write, pc_write, pc_write_cond;
   logic [1:0]  pc_source, alu_src_b;
   logic [2:0]  alu_op;
   logic        alu_src_a, reg_write, reg_dst, mem_to_reg;
   logic        instr_done, illegal_op, mem_timeout;
   logic [3:0]  state;

   multicycle_control #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .mem_read(mem_read), .mem_write(mem_write), .ior_d(ior_d), .ir_write(ir_write),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [19:0] IRW  = 20'h10000;
   localparam logic [19:0] PCW  = 20'h08000;
   localparam logic [19:0] DONE = 20'h00004;
   localparam logic [19:0] ILL  = 20'h00002;
   localparam logic [19:0] TOUT = 20'h00001;

   typedef struct {
      logic        rdy;
      logic        rn;
      logic [5:0]  op;
      logic [3:0]  st;
      logic [19:0] ctl;
   } step_t;

   step_t      q[$];
   logic [5:0] cur_op;
   int         n_checks = 0;
   int         n_pass   = 0;

   function automatic logic [19:0] obs_ctrl();
      return {mem_read, mem_write, ior_d, ir_write, pc_write, pc_write_cond, pc_source,
              alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg,
              instr_done, illegal_op, mem_timeout};
   endfunction

   // Per-state control table (Moore part only)
   function automatic logic [19:0] base_ctrl(input int s);
      logic mr, mw, io, pw, pwc, asa, rw, rd, m2r;
      logic [1:0] ps, asb;
      logic [2:0] op;
      {mr, mw, io, pw, pwc, asa, rw, rd, m2r} = 9'b0;
      ps = 2'b00; asb = 2'b00; op = 3'b000;
      case (s)
         1:  begin mr = 1'b1; asb = 2'b01; end
         2:  asb = 2'b11;
         3:  begin asa = 1'b1; asb = 2'b10; end
         4:  begin mr = 1'b1; io = 1'b1; end
         5:  begin rw = 1'b1; m2r = 1'b1; end
         6:  begin mw = 1'b1; io = 1'b1; end
         7:  begin asa = 1'b1; op = 3'b010; end
         8:  begin rw = 1'b1; rd = 1'b1; end
         9:  begin asa = 1'b1; op = 3'b001; pwc = 1'b1; ps = 2'b01; end
         10: begin pw = 1'b1; ps = 2'b10; end
         11: begin asa = 1'b1; asb = 2'b10; end
         12: rw = 1'b1;
         default: mr = 1'b0;
      endcase
      return {mr, mw, io, 1'b0, pw, pwc, ps, op, asa, asb, rw, rd, m2r, 3'b000};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      bit ok;
      ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010);
`ifdef MC_ADDI_EN
      ok = ok || (op == 6'b001000);
`endif
      return ok;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
   endtask

   function automatic logic rbit();
      return logic'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic rdy, input logic rn, input int st, input logic [19:0] extra);
      step_t s;
      s.rdy = rdy; s.rn = rn; s.op = cur_op; s.st = 4'(st);
      s.ctl = (st == 0) ? 20'h0 : (base_ctrl(st) | extra);
      q.push_back(s);
   endtask

   // Memory wait of n idle cycles in state st; returns 1 when it aborted on timeout
   task automatic stall(input int st, input int n, output bit aborted);
      aborted = 1'b0;
      for (int k = 1; k <= n; k++) begin
         if (k % TMO == 0 && st != 1) begin
            push(1'b0, 1'b0, st, TOUT);
            aborted = 1'b1;
            return;
         end
         push(1'b0, rbit(), st, (k % TMO == 0) ? TOUT : 20'h0);
      end
   endtask

   task automatic finish_instr(input logic run_after);
      if (!run_after) begin
         for (int i = 0; i < 1 + int'($urandom_range(0, 1)); i++) push(rbit(), 1'b0, 0, 20'h0);
         push(rbit(), 1'b1, 0, 20'h0);
      end
   endtask

   // kind: 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 illegal, 6 addi
   task automatic gen_instr(input int kind, input int fst, input int mst, input logic run_after);
      bit ab;
      case (kind)
         0: cur_op = 6'b000000;
         1: cur_op = 6'b100011;
         2: cur_op = 6'b101011;
         3: cur_op = 6'b000100;
         4: cur_op = 6'b000010;
         6: cur_op = 6'b001000;
         default: begin
            cur_op = 6'($urandom);
            while (is_legal(cur_op)) cur_op = 6'($urandom);
         end
      endcase
      stall(1, fst, ab);
      push(1'b1, rbit(), 1, IRW | PCW);
      if (!is_legal(cur_op)) begin
         push(rbit(), run_after, 2, ILL | DONE);
         finish_instr(run_after);
         return;
      end
      push(rbit(), rbit(), 2, 20'h0);
      case (kind)
         0: begin push(rbit(), rbit(), 7, 20'h0); push(rbit(), run_after, 8, DONE); end
         1: begin
            push(rbit(), rbit(), 3, 20'h0);
            stall(4, mst, ab);
            if (ab) return;
            push(1'b1, rbit(), 4, 20'h0);
            push(rbit(), run_after, 5, DONE);
         end
         2: begin
            push(rbit(), rbit(), 3, 20'h0);
            stall(6, mst, ab);
            if (ab) return;
            push(1'b1, run_after, 6, DONE);
         end
         3: push(rbit(), run_after, 9, DONE);
         4: push(rbit(), run_after, 10, DONE);
         default: begin push(rbit(), rbit(), 11, 20'h0); push(rbit(), run_after, 12, DONE); end
      endcase
      finish_instr(run_after);
   endtask

   task automatic run_queue();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         run = s.rn; mem_ready = s.rdy; opcode = s.op;
         #1;
         check("state", {28'd0, state}, {28'd0, s.st});
         check("ctrl", {12'd0, obs_ctrl()}, {12'd0, s.ctl});
      end
   endtask

   initial begin
      int fst_tab[7] = '{0, 0, 1, 2, 15, 16, 20};
      int mst_tab[6] = '{0, 1, 2, 3, 15, 16};
      rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'd0; cur_op = 6'd0;
      repeat (2) @(negedge clk);
      check("rst_state", {28'd0, state}, 32'd0);
      check("rst_ctrl", {12'd0, obs_ctrl()}, 32'd0);
      rst_n = 1'b1;
      push(1'b0, 1'b1, 0, 20'h0);
      gen_instr(0, 0, 0, 1'b1);
      gen_instr(1, 0, 3, 1'b1);
      gen_instr(3, 0, 0, 1'b1);
      gen_instr(4, 0, 0, 1'b0);
      gen_instr(0, 16, 0, 1'b1);
      gen_instr(0, 15, 0, 1'b1);
      gen_instr(1, 0, 16, 1'b1);
      gen_instr(2, 1, 16, 1'b1);
      gen_instr(2, 0, 15, 1'b1);
      gen_instr(6, 0, 0, 1'b1);
      gen_instr(5, 0, 0, 1'b0);
      run_queue();
      for (int i = 0; i < 40; i++) begin
         gen_instr(int'($urandom_range(0, 6)), fst_tab[$urandom_range(0, 6)],
                   mst_tab[$urandom_range(0, 5)], logic'($urandom_range(0, 3) != 0));
         run_queue();
      end
      gen_instr(0, 0, 0, 1'b1);
      void'(q.pop_back());
      run_queue();
      rst_n = 1'b0;
      #1;
      check("midrst_state", {28'd0, state}, 32'd0);
      check("midrst_ctrl", {12'd0, obs_ctrl()}, 32'd0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
